regfile_wb_scheduler: RTL and testbench

Issue scoreboard and write-port scheduler for the 32×32 register bank. Tracks which architectural registers have an in-flight write, stalls decode on RAW/WAW hazards, and arbitrates the bank's single write port between the ALU and memory writeback sources. Sits between decode/execute/memory and the register bank write port (`write`, `addr_d`, `data`).

---
 rtl/rf_pkg.sv | 19 +
 rtl/wb_rr_arbiter.sv | 32 +++
 rtl/regfile_wb_scheduler.sv | 105 ++++++++++
 tb/tb_regfile_wb_scheduler.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rf_pkg.sv
// Shared widths, writeback source encoding and write payload for the
// register bank writeback path.
package rf_pkg;

  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  typedef enum logic {
    WB_ALU = 1'b0,
    WB_MEM = 1'b1
  } wb_src_t;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } rf_wr_t;

endpackage

// File: rtl/wb_rr_arbiter.sv
// Two-requester round-robin arbiter for the bank write port; the registered
// pointer remembers the last source granted.
module wb_rr_arbiter
  import rf_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic req_alu,
  input  logic req_mem,
  output logic gnt_alu_c,
  output logic gnt_mem_c
);

  wb_src_t last_q;

  // Out of reset the pointer reads as "MEM last", so ALU wins the first tie.
  always_comb begin
    gnt_alu_c = req_alu && (!req_mem || (last_q == WB_MEM));
    gnt_mem_c = req_mem && !gnt_alu_c;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_q <= WB_MEM;
    end else if (gnt_alu_c) begin
      last_q <= WB_ALU;
    end else if (gnt_mem_c) begin
      last_q <= WB_MEM;
    end
  end

endmodule

// File: rtl/regfile_wb_scheduler.sv
// Issue scoreboard and write-port scheduler for the register bank: stalls
// decode on RAW/WAW hazards and funnels ALU/MEM writebacks onto one port.
module regfile_wb_scheduler
  import rf_pkg::*;
#(
  parameter int unsigned NREGS = rf_pkg::NREGS,
  parameter int unsigned AW    = rf_pkg::AW,
  parameter int unsigned DW    = rf_pkg::DW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_src_a,
  input  logic [AW-1:0]    issue_src_b,
  input  logic             issue_use_a,
  input  logic             issue_use_b,
  input  logic [AW-1:0]    issue_dst,
  input  logic             issue_wr,
  output logic             issue_stall,
  input  logic             alu_wb_valid,
  input  logic [AW-1:0]    alu_wb_addr,
  input  logic [DW-1:0]    alu_wb_data,
  output logic             alu_wb_ready,
  input  logic             mem_wb_valid,
  input  logic [AW-1:0]    mem_wb_addr,
  input  logic [DW-1:0]    mem_wb_data,
  output logic             mem_wb_ready,
  output logic             rf_write,
  output logic [AW-1:0]    rf_addr_d,
  output logic [DW-1:0]    rf_data,
  output logic [NREGS-1:0] busy_mask,
  output logic             wb_err
);

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_nxt;
  logic             issue_acc;
  logic             wb_fire;
  logic             wb_to_reg;
  rf_wr_t           wb_sel;

  wb_rr_arbiter u_arb (
    .clk       (clk),
    .reset     (reset),
    .req_alu   (alu_wb_valid),
    .req_mem   (mem_wb_valid),
    .gnt_alu_c (alu_wb_ready),
    .gnt_mem_c (mem_wb_ready)
  );

  // Hazard check sees only the registered scoreboard; a clear lands one cycle later.
  always_comb begin
    issue_stall = issue_valid &&
                  ((issue_use_a && busy[issue_src_a]) ||
                   (issue_use_b && busy[issue_src_b]) ||
                   (issue_wr    && busy[issue_dst]));
    issue_acc   = issue_valid && !issue_stall;
  end

  always_comb begin
    wb_sel.addr = mem_wb_addr;
    wb_sel.data = mem_wb_data;
    if (alu_wb_ready) begin
      wb_sel.addr = alu_wb_addr;
      wb_sel.data = alu_wb_data;
    end
    wb_fire   = alu_wb_ready || mem_wb_ready;
    wb_to_reg = wb_fire && (wb_sel.addr != '0);
  end

  // Clear on commit, then set on issue so a same-edge collision leaves the bit set.
  always_comb begin
    busy_nxt = busy;
    if (rf_write) begin
      busy_nxt[rf_addr_d] = 1'b0;
    end
    if (issue_acc && issue_wr && (issue_dst != '0)) begin
      busy_nxt[issue_dst] = 1'b1;
    end
    busy_nxt[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy      <= '0;
      rf_write  <= 1'b0;
      rf_addr_d <= '0;
      rf_data   <= '0;
      wb_err    <= 1'b0;
    end else begin
      busy     <= busy_nxt;
      rf_write <= wb_to_reg;
      if (wb_to_reg) begin
        rf_addr_d <= wb_sel.addr;
        rf_data   <= wb_sel.data;
        if (!busy[wb_sel.addr]) begin
          wb_err <= 1'b1;
        end
      end
    end
  end

  assign busy_mask = busy;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Directed bench for regfile_wb_scheduler: hazards, arbitration, r0 and
// unexpected writebacks, asynchronous reset.
module tb_regfile_wb_scheduler;

  logic        clk = 1'b0;
  logic        reset;
  logic        issue_valid;
  logic [4:0]  issue_src_a, issue_src_b, issue_dst;
  logic        issue_use_a, issue_use_b, issue_wr;
  logic        issue_stall;
  logic        alu_wb_valid;
  logic [4:0]  alu_wb_addr;
  logic [31:0] alu_wb_data;
  logic        alu_wb_ready;
  logic        mem_wb_valid;
  logic [4:0]  mem_wb_addr;
  logic [31:0] mem_wb_data;
  logic        mem_wb_ready;
  logic        rf_write;
  logic [4:0]  rf_addr_d;
  logic [31:0] rf_data;
  logic [31:0] busy_mask;
  logic        wb_err;

  int total = 0;
  int bad   = 0;

  regfile_wb_scheduler dut (
    .clk          (clk),
    .reset        (reset),
    .issue_valid  (issue_valid),
    .issue_src_a  (issue_src_a),
    .issue_src_b  (issue_src_b),
    .issue_use_a  (issue_use_a),
    .issue_use_b  (issue_use_b),
    .issue_dst    (issue_dst),
    .issue_wr     (issue_wr),
    .issue_stall  (issue_stall),
    .alu_wb_valid (alu_wb_valid),
    .alu_wb_addr  (alu_wb_addr),
    .alu_wb_data  (alu_wb_data),
    .alu_wb_ready (alu_wb_ready),
    .mem_wb_valid (mem_wb_valid),
    .mem_wb_addr  (mem_wb_addr),
    .mem_wb_data  (mem_wb_data),
    .mem_wb_ready (mem_wb_ready),
    .rf_write     (rf_write),
    .rf_addr_d    (rf_addr_d),
    .rf_data      (rf_data),
    .busy_mask    (busy_mask),
    .wb_err       (wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic ua, input logic [4:0] a,
                           input logic wr, input logic [4:0] d);
    issue_valid = v;
    issue_use_a = ua;
    issue_src_a = a;
    issue_use_b = 1'b0;
    issue_src_b = 5'd0;
    issue_wr    = wr;
    issue_dst   = d;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    alu_wb_valid = v;
    alu_wb_addr  = a;
    alu_wb_data  = d;
  endtask

  task automatic set_mem(input logic v, input logic [4:0] a, input logic [31:0] d);
    mem_wb_valid = v;
    mem_wb_addr  = a;
    mem_wb_data  = d;
  endtask

  initial begin
    reset = 1'b1;
    set_issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b0, 5'd0, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy_mask), 64'h0);
    chk("rst_write", 64'(rf_write), 64'h0);
    chk("rst_err", 64'(wb_err), 64'h0);
    chk("rst_addr", 64'(rf_addr_d), 64'h0);
    chk("rst_data", 64'(rf_data), 64'h0);
    reset = 1'b0;

    // independent read of r5
    set_issue(1'b1, 1'b1, 5'd5, 1'b0, 5'd0);
    #1 chk("r5_nostall", 64'(issue_stall), 64'h0);
    chk("idle_alu_rdy", 64'(alu_wb_ready), 64'h0);
    step();

    // RAW on r3
    set_issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd3);
    #1 chk("r3_issue", 64'(issue_stall), 64'h0);
    step();
    set_issue(1'b1, 1'b1, 5'd3, 1'b0, 5'd0);
    set_alu(1'b1, 5'd3, 32'hDEADBEEF);
    #1 chk("raw_stall_t", 64'(issue_stall), 64'h1);
    chk("raw_busy", 64'(busy_mask), 64'h8);
    chk("raw_alu_rdy", 64'(alu_wb_ready), 64'h1);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    #1 chk("raw_wr", 64'(rf_write), 64'h1);
    chk("raw_addr", 64'(rf_addr_d), 64'h3);
    chk("raw_data", 64'(rf_data), 64'hDEADBEEF);
    chk("raw_stall_t1", 64'(issue_stall), 64'h1);
    step();
    #1 chk("raw_stall_t2", 64'(issue_stall), 64'h0);
    chk("raw_busy_clr", 64'(busy_mask), 64'h0);
    chk("raw_wr_off", 64'(rf_write), 64'h0);
    step();

    // WAW on r7
    set_issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd7);
    #1 chk("waw_first", 64'(issue_stall), 64'h0);
    step();
    set_alu(1'b1, 5'd7, 32'h77);
    #1 chk("waw_stall0", 64'(issue_stall), 64'h1);
    chk("waw_busy", 64'(busy_mask), 64'h80);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    #1 chk("waw_stall1", 64'(issue_stall), 64'h1);
    chk("waw_wr_addr", 64'(rf_addr_d), 64'h7);
    step();
    #1 chk("waw_release", 64'(issue_stall), 64'h0);
    step();
    set_issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_alu(1'b1, 5'd7, 32'h78);
    #1 chk("waw_busy_again", 64'(busy_mask), 64'h80);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    #1 chk("waw_wr2", 64'(rf_data), 64'h78);
    step();
    #1 chk("waw_busy_clr", 64'(busy_mask), 64'h0);
    chk("waw_err", 64'(wb_err), 64'h0);

    // round robin, pointer freshly reset
    reset = 1'b1;
    #1 reset = 1'b0;
    step();
    for (int i = 1; i <= 4; i++) begin
      set_issue(1'b1, 1'b0, 5'd0, 1'b1, 5'(i));
      step();
    end
    set_issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    #1 chk("rr_busy", 64'(busy_mask), 64'h1E);
    set_alu(1'b1, 5'd1, 32'hA1);
    set_mem(1'b1, 5'd2, 32'hB2);
    #1 chk("rr0_alu", 64'(alu_wb_ready), 64'h1);
    chk("rr0_mem", 64'(mem_wb_ready), 64'h0);
    step();
    set_alu(1'b1, 5'd3, 32'hA3);
    #1 chk("rr1_wr", 64'({rf_write, rf_addr_d, rf_data}), {1'b1, 5'd1, 32'hA1});
    chk("rr1_mem", 64'(mem_wb_ready), 64'h1);
    chk("rr1_alu", 64'(alu_wb_ready), 64'h0);
    step();
    set_mem(1'b1, 5'd4, 32'hB4);
    #1 chk("rr2_wr", 64'({rf_write, rf_addr_d, rf_data}), {1'b1, 5'd2, 32'hB2});
    chk("rr2_alu", 64'(alu_wb_ready), 64'h1);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    #1 chk("rr3_wr", 64'({rf_write, rf_addr_d, rf_data}), {1'b1, 5'd3, 32'hA3});
    chk("rr3_mem", 64'(mem_wb_ready), 64'h1);
    step();
    set_mem(1'b0, 5'd0, 32'd0);
    #1 chk("rr4_wr", 64'({rf_write, rf_addr_d, rf_data}), {1'b1, 5'd4, 32'hB4});
    step();
    #1 chk("rr_wr_off", 64'(rf_write), 64'h0);
    chk("rr_busy_clr", 64'(busy_mask), 64'h0);
    chk("rr_err", 64'(wb_err), 64'h0);

    // writeback to r0 is a discarded handshake
    set_mem(1'b1, 5'd0, 32'h55);
    #1 chk("r0_mem_rdy", 64'(mem_wb_ready), 64'h1);
    step();
    set_mem(1'b0, 5'd0, 32'd0);
    #1 chk("r0_nowrite", 64'(rf_write), 64'h0);
    chk("r0_busy", 64'(busy_mask), 64'h0);
    chk("r0_err", 64'(wb_err), 64'h0);

    // writeback to a non-busy register flags an error
    set_alu(1'b1, 5'd9, 32'h99);
    #1 chk("r9_alu_rdy", 64'(alu_wb_ready), 64'h1);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    #1 chk("r9_wr", 64'({rf_write, rf_addr_d, rf_data}), {1'b1, 5'd9, 32'h99});
    chk("r9_err", 64'(wb_err), 64'h1);
    step();
    step();
    chk("r9_err_sticky", 64'(wb_err), 64'h1);

    // asynchronous reset with r2 busy and a grant pending
    set_issue(1'b1, 1'b0, 5'd0, 1'b1, 5'd2);
    step();
    set_issue(1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    set_alu(1'b1, 5'd2, 32'h22);
    #1 chk("mr_busy", 64'(busy_mask), 64'h4);
    step();
    set_alu(1'b0, 5'd0, 32'd0);
    set_mem(1'b1, 5'd5, 32'h5555);
    #1 chk("mr_wr", 64'(rf_write), 64'h1);
    chk("mr_mem_rdy", 64'(mem_wb_ready), 64'h1);
    reset = 1'b1;
    #1 chk("mr_busy_rst", 64'(busy_mask), 64'h0);
    chk("mr_wr_rst", 64'(rf_write), 64'h0);
    chk("mr_err_rst", 64'(wb_err), 64'h0);
    set_mem(1'b0, 5'd0, 32'd0);
    step();
    reset = 1'b0;
    step();
    chk("mr_post_wr0", 64'(rf_write), 64'h0);
    chk("mr_post_busy", 64'(busy_mask), 64'h0);
    step();
    chk("mr_post_wr1", 64'(rf_write), 64'h0);
    chk("mr_post_addr", 64'(rf_addr_d), 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
